seg7_decimal_scan: RTL and testbench
====================================

Name: seg7_decimal_scan

Overview:
- Parametrised successor to the team's single-digit BCD-to-7-segment decoder.
- Drives a DIGITS-wide multiplexed common-anode display from a packed BCD word.
- Adds value snapshotting (tear-free), time-multiplexed digit scanning, leading-zero blanking, per-digit decimal points and ghost-suppression guard cycles.
- Sits between the datapath producing a displayed value and the board's segment/anode pins.

Parameters:
- DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clock cycles each digit stays selected; must be >= 2.
- LZ_BLANK, 1, 1 = blank leading zeros; 0 = show every digit.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, synchronous active-high reset.
- value_in, input, 4*DIGITS, packed BCD; digit k = value_in[4k+3:4k], digit 0 is least significant.
- dp_in, input, DIGITS, decimal point request per digit, 1 = lit.
- load, input, 1, when 1, capture value_in and dp_in into the snapshot at the clock edge.
- seg, output, 7, active-low segments; MSB = A, LSB = G.
- dp, output, 1, active-low decimal point.
- an, output, DIGITS, active-low one-hot digit enable.

Behaviour:
- Reset (rst=1 at a clock edge): cnt=0, idx=0, snapshot value=0, snapshot dp=0, seg=7'b1111111, dp=1, an=all ones. load is ignored while rst=1.
- Snapshot: on an edge with load=1, value_snap<=value_in and dp_snap<=dp_in. Only the snapshot is displayed. A load mid-digit takes effect at the next registered output update. A digit is never built from mixed old and new data.
- Refresh counter:
  - cnt runs 0..REFRESH_DIV-1. At REFRESH_DIV-1, cnt wraps to 0 and idx advances.
  - idx advances as DIGITS-1 -> 0, otherwise idx+1.
  - DIGITS=1: idx stays 0.
- Outputs are registered, with one cycle of latency from (cnt, idx, snapshot) to (seg, dp, an).
  - Guard cycle: when cnt==0, the next outputs are an=all ones, seg=7'b1111111, dp=1. This suppresses ghosting at every digit switch, including the first period after reset.
  - Otherwise an has only bit idx low.
  - seg = decode(digit idx).
  - dp = ~dp_snap[idx].
- Decode table (0 = lit):
  - 0:0000001, 1:1001111, 2:0010010, 3:0000110, 4:1001100
  - 5:0100100, 6:0100000, 7:0001111, 8:0000000, 9:0000100
  - 10..15: 1111110 (dash, G only)
- Leading-zero blanking (LZ_BLANK=1):
  - Digit k is blanked (seg=1111111) if it and every digit above it equal 0 and k != 0.
  - Digit 0 always displays, so value 0 shows a single "0".
  - Codes 10..15 count as nonzero.
  - Blanking never suppresses dp: a requested dp stays lit on a blanked digit.
- LZ_BLANK=0: every digit is decoded.
- Full scan period is DIGITS*REFRESH_DIV cycles. Each digit is lit REFRESH_DIV-1 cycles per period.
- Reset asserted mid-scan: outputs return to their reset values on the following edge. Scanning resumes from idx=0, cnt=0.

Test Plan:
1. DIGITS=4, REFRESH_DIV=4; hold rst=1 for 3 cycles, then release.
   - Required: seg=1111111, an=1111, dp=1 during reset and during the first guard cycle.
   - Then an=1110 with seg=0000001 (value 0).
   - Digits 1..3 blanked with an cycling 1101, 1011, 0111.
2. load=1 with value_in=16'h0907, dp_in=4'b0010.
   - digit0 seg=0001111 (7); digit1 seg=0000001 (0, not leading), dp=0 (lit); digit2 seg=0000100 (9); digit3 blank.
   - Scan period = 16 cycles; exactly one guard cycle every 4 cycles.
3. value_in=16'h00A0 loaded, LZ_BLANK=1.
   - digit1 shows dash 1111110; digit0 shows 0000001; digits 2,3 blank.
   - Repeat with LZ_BLANK=0: digits 2,3 show 0000001.
4. Change value_in without load.
   - Display unchanged.
   - Pulse load while idx=2 and cnt=2: the new digit appears on the next registered update, with no tear.
5. Assert rst for one cycle while idx=3.
   - Next cycle: an=1111, seg=1111111; scan restarts at digit 0.
   - A load asserted in the same cycle as rst is ignored: snapshot = 0.
6. DIGITS=1, REFRESH_DIV=2, value 5.
   - an alternates 1 (guard) / 0; seg=0100100 on lit cycles.

Source files
------------

// File: rtl/seg7_decimal_scan.sv
// Multiplexed common-anode 7-segment driver: snapshots a packed BCD word, scans digits with
// a guard cycle at each switch, blanks leading zeros and drives per-digit decimal points.
module seg7_decimal_scan #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  load,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CW-1:0]       cnt;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] value_snap;
  logic [DIGITS-1:0]   dp_snap;

  logic [3:0]          cur_digit;
  logic                cur_dp;
  logic                cur_blank;
  logic                run_zero;
  logic [DIGITS-1:0]   zero_from;
  logic [DIGITS-1:0]   an_sel;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0000001;
      4'd1:    decode = 7'b1001111;
      4'd2:    decode = 7'b0010010;
      4'd3:    decode = 7'b0000110;
      4'd4:    decode = 7'b1001100;
      4'd5:    decode = 7'b0100100;
      4'd6:    decode = 7'b0100000;
      4'd7:    decode = 7'b0001111;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0000100;
      default: decode = 7'b1111110;
    endcase
  endfunction

  // zero_from[k]: digit k and every digit above it are zero (codes 10..15 count as nonzero)
  always_comb begin
    run_zero  = 1'b1;
    zero_from = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      run_zero     = run_zero && (value_snap[4*k +: 4] == 4'd0);
      zero_from[k] = run_zero;
    end
  end

  always_comb begin
    cur_digit = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    an_sel    = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx == IW'(k)) begin
        cur_digit = value_snap[4*k +: 4];
        cur_dp    = dp_snap[k];
        cur_blank = (LZ_BLANK != 0) && (k != 0) && zero_from[k];
        an_sel[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      value_snap <= '0;
      dp_snap    <= '0;
      seg        <= 7'b1111111;
      dp         <= 1'b1;
      an         <= '1;
    end else begin
      if (load) begin
        value_snap <= value_in;
        dp_snap    <= dp_in;
      end

      if (cnt == CW'(REFRESH_DIV - 1)) begin
        cnt <= '0;
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      // First cycle of every digit slot is dark to avoid ghosting on the anode switch
      if (cnt == '0) begin
        seg <= 7'b1111111;
        dp  <= 1'b1;
        an  <= '1;
      end else begin
        seg <= cur_blank ? 7'b1111111 : decode(cur_digit);
        dp  <= ~cur_dp;
        an  <= an_sel;
      end
    end
  end

endmodule

// File: tb/tb_seg7_decimal_scan.sv
// Directed bench for seg7_decimal_scan: two 4-digit instances (blanking on/off) share stimulus,
// a 1-digit instance is exercised separately at the end.
module tb_seg7_decimal_scan;

  localparam logic [6:0] B  = 7'b1111111;
  localparam logic [6:0] S0 = 7'b0000001;
  localparam logic [6:0] S5 = 7'b0100100;
  localparam logic [6:0] S6 = 7'b0100000;
  localparam logic [6:0] S7 = 7'b0001111;
  localparam logic [6:0] S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0000100;
  localparam logic [6:0] SD = 7'b1111110;

  logic        clk = 1'b0;
  logic        rst, load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg_a, seg_b, seg_c;
  logic        dp_a, dp_b, dp_c;
  logic [3:0]  an_a, an_b;
  logic [0:0]  an_c;
  logic        rst1, load1;
  logic [3:0]  value1;
  logic [0:0]  dp_in1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seg7_decimal_scan #(.DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(1)) u_lz (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .load(load),
    .seg(seg_a), .dp(dp_a), .an(an_a));

  seg7_decimal_scan #(.DIGITS(4), .REFRESH_DIV(4), .LZ_BLANK(0)) u_nolz (
    .clk(clk), .rst(rst), .value_in(value_in), .dp_in(dp_in), .load(load),
    .seg(seg_b), .dp(dp_b), .an(an_b));

  seg7_decimal_scan #(.DIGITS(1), .REFRESH_DIV(2), .LZ_BLANK(1)) u_one (
    .clk(clk), .rst(rst1), .value_in(value1), .dp_in(dp_in1), .load(load1),
    .seg(seg_c), .dp(dp_c), .an(an_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Slot s of a 16-cycle period: digit s/4, cnt s%4. ea/eb = expected seg per digit, edp = dp request.
  task automatic scan_range(input string tag, input int first, input int last,
                            input logic [27:0] ea, input logic [27:0] eb, input logic [3:0] edp);
    logic [3:0] oh;
    int d, c;
    for (int s = first; s <= last; s++) begin
      step();
      load = 1'b0;
      d  = s / 4;
      c  = s % 4;
      oh = 4'b0001 << d;
      if (c == 0) begin
        chk($sformatf("%s guard lz s%0d", tag, s),   {an_a, seg_a, dp_a}, {4'b1111, B, 1'b1});
        chk($sformatf("%s guard nolz s%0d", tag, s), {an_b, seg_b, dp_b}, {4'b1111, B, 1'b1});
      end else begin
        chk($sformatf("%s lz s%0d", tag, s),   {an_a, seg_a, dp_a}, {~oh, ea[7*d +: 7], ~edp[d]});
        chk($sformatf("%s nolz s%0d", tag, s), {an_b, seg_b, dp_b}, {~oh, eb[7*d +: 7], ~edp[d]});
      end
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value_in = '0; dp_in = '0;
    rst1 = 1'b1; load1 = 1'b0; value1 = '0; dp_in1 = '0;

    // Reset held three cycles
    for (int i = 0; i < 3; i++) begin
      step();
      chk("reset lz",   {an_a, seg_a, dp_a}, {4'b1111, B, 1'b1});
      chk("reset nolz", {an_b, seg_b, dp_b}, {4'b1111, B, 1'b1});
    end
    rst = 1'b0;
    scan_range("zero", 0, 15, {B, B, B, S0}, {S0, S0, S0, S0}, 4'b0000);

    // 0907 with dp on digit 1
    value_in = 16'h0907; dp_in = 4'b0010; load = 1'b1;
    scan_range("0907", 0, 15, {B, S9, S0, S7}, {S0, S9, S0, S7}, 4'b0010);

    // 00A0: dash counts as nonzero
    value_in = 16'h00A0; dp_in = 4'b0000; load = 1'b1;
    scan_range("00A0", 0, 15, {B, B, SD, S0}, {S0, S0, SD, S0}, 4'b0000);

    // New input without load is not displayed
    value_in = 16'h1234;
    scan_range("noload", 0, 15, {B, B, SD, S0}, {S0, S0, SD, S0}, 4'b0000);

    // Load at idx=2, cnt=2: that slot still shows old data, the next one the new data
    scan_range("preload", 0, 9, {B, B, SD, S0}, {S0, S0, SD, S0}, 4'b0000);
    value_in = 16'h5678; dp_in = 4'b0100; load = 1'b1;
    scan_range("loadslot", 10, 10, {B, B, SD, S0}, {S0, S0, SD, S0}, 4'b0000);
    scan_range("postload", 11, 15, {S5, S6, S7, S8}, {S5, S6, S7, S8}, 4'b0100);
    scan_range("5678", 0, 12, {S5, S6, S7, S8}, {S5, S6, S7, S8}, 4'b0100);

    // One-cycle reset while idx=3, with a simultaneous load that must be ignored
    rst = 1'b1; load = 1'b1; value_in = 16'h9999; dp_in = 4'b1111;
    step();
    chk("midrst lz",   {an_a, seg_a, dp_a}, {4'b1111, B, 1'b1});
    chk("midrst nolz", {an_b, seg_b, dp_b}, {4'b1111, B, 1'b1});
    rst = 1'b0; load = 1'b0;
    scan_range("afterrst", 0, 15, {B, B, B, S0}, {S0, S0, S0, S0}, 4'b0000);

    // Single digit, REFRESH_DIV=2: guard and lit alternate
    value1 = 4'd5; dp_in1 = 1'b1;
    step();
    chk("one reset", {3'b000, an_c, seg_c, dp_c}, {3'b000, 1'b1, B, 1'b1});
    rst1 = 1'b0; load1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      load1 = 1'b0;
      chk($sformatf("one guard %0d", i), {3'b000, an_c, seg_c, dp_c}, {3'b000, 1'b1, B, 1'b1});
      step();
      chk($sformatf("one lit %0d", i),   {3'b000, an_c, seg_c, dp_c}, {3'b000, 1'b0, S5, 1'b0});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
